// File: rtl/digest_out_sequencer_pkg.sv
// Shared types and constants for the digest output sequencer.
// Digest word order: H0 is the most significant word of the packed input.
package digest_pkg;

  localparam int WORD_W    = 32;
  localparam int NUM_WORDS = 8;
  localparam int IDX_W     = 3;

  localparam logic [IDX_W-1:0] LAST_IDX =
    IDX_W'(NUM_WORDS - 1);

  typedef enum logic [1:0] {
    EMPTY,
    HOLD,
    STREAM
  } state_t;

  typedef logic [NUM_WORDS-1:0][WORD_W-1:0] digest_words_t;

  function automatic digest_words_t unpack_digest(
    input logic [NUM_WORDS*WORD_W-1:0] d
  );
    digest_words_t w;
    for (int i = 0; i < NUM_WORDS; i++) begin
      w[i] = d[WORD_W*(NUM_WORDS-1-i) +: WORD_W];
    end
    return w;
  endfunction

endpackage

// File: rtl/digest_out_sequencer_if.sv
// Word stream toward the display driver / UART packer.
// The sequencer is master; the consumer only drives out_ready.
interface digest_out_sequencer_if;
  import digest_pkg::*;

  logic [WORD_W-1:0] word_out;
  logic [IDX_W-1:0]  word_idx;
  logic              out_valid;
  logic              out_last;
  logic              out_ready;

  modport master (
    output word_out,
    output word_idx,
    output out_valid,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  word_out,
    input  word_idx,
    input  out_valid,
    input  out_last,
    output out_ready
  );

endinterface

// File: rtl/digest_word_mux.sv
// Combinational 8:1 digest word selector.
// The caller registers the result.
module digest_word_mux
  import digest_pkg::*;
(
  input  digest_words_t     words,
  input  logic [IDX_W-1:0]  ptr,
  output logic [WORD_W-1:0] word
);

  assign word = words[ptr];

endmodule

// File: rtl/digest_out_sequencer.sv
// Holds the final digest and presents it one word at a time,
// either from the switch index or as a valid/ready stream.
module digest_out_sequencer
  import digest_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        digest_valid,
  input  logic [NUM_WORDS*WORD_W-1:0] digest_in,
  input  logic                        mode,
  input  logic [IDX_W-1:0]            sel,
  digest_out_sequencer_if.master      stream,
  output logic                        busy,
  output logic                        overrun
);

  state_t            state, state_nxt;
  logic [IDX_W-1:0]  idx, idx_nxt;
  digest_words_t     store, store_nxt;
  logic              capture, drop;
  logic              hs, last_hs;
  logic [IDX_W-1:0]  ptr;
  logic [WORD_W-1:0] mux_word;

  logic [WORD_W-1:0] word_nxt;
  logic [IDX_W-1:0]  widx_nxt;
  logic              valid_nxt, last_nxt;

  assign hs      = stream.out_valid && stream.out_ready;
  assign last_hs = hs && (idx == LAST_IDX);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= EMPTY;
      idx     <= '0;
      store   <= '0;
      overrun <= 1'b0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      store <= store_nxt;
      if (drop) overrun <= 1'b1;
    end
  end

  // Mode is only honoured outside a stream or on its final handshake.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    capture   = 1'b0;
    drop      = 1'b0;
    unique case (state)
      EMPTY, HOLD: begin
        if (digest_valid) begin
          capture   = 1'b1;
          state_nxt = mode ? STREAM : HOLD;
          idx_nxt   = '0;
        end else if (state == HOLD && mode) begin
          state_nxt = STREAM;
          idx_nxt   = '0;
        end
      end
      STREAM: begin
        drop = digest_valid && !last_hs;
        if (last_hs) begin
          capture   = digest_valid;
          state_nxt = mode ? STREAM : HOLD;
          idx_nxt   = '0;
        end else if (hs) begin
          idx_nxt = idx + 1'b1;
        end
      end
      default: state_nxt = EMPTY;
    endcase
  end

  // Read the post-capture contents so a new digest shows next cycle.
  assign store_nxt = capture ? unpack_digest(digest_in) : store;
  assign ptr = (state_nxt == STREAM) ? idx_nxt : sel;

  digest_word_mux u_mux (
    .words (store_nxt),
    .ptr   (ptr),
    .word  (mux_word)
  );

  always_comb begin
    word_nxt  = '0;
    widx_nxt  = '0;
    valid_nxt = 1'b0;
    last_nxt  = 1'b0;
    unique case (state_nxt)
      HOLD: begin
        word_nxt = mux_word;
        widx_nxt = sel;
      end
      STREAM: begin
        word_nxt  = mux_word;
        widx_nxt  = idx_nxt;
        valid_nxt = 1'b1;
        last_nxt  = (idx_nxt == LAST_IDX);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stream.word_out  <= '0;
      stream.word_idx  <= '0;
      stream.out_valid <= 1'b0;
      stream.out_last  <= 1'b0;
      busy             <= 1'b0;
    end else begin
      stream.word_out  <= word_nxt;
      stream.word_idx  <= widx_nxt;
      stream.out_valid <= valid_nxt;
      stream.out_last  <= last_nxt;
      busy             <= valid_nxt;
    end
  end

endmodule

// File: tb/tb_digest_out_sequencer.sv
// Bench for digest_out_sequencer: directed scenarios plus
// randomized traffic against a behavioural model.
module tb_digest_out_sequencer;

  logic         clk = 1'b0;
  logic         rst;
  logic         digest_valid;
  logic [255:0] digest_in;
  logic         mode;
  logic [2:0]   sel;
  logic         busy;
  logic         overrun;

  digest_out_sequencer_if bus();

  digest_out_sequencer dut (
    .clk          (clk),
    .rst          (rst),
    .digest_valid (digest_valid),
    .digest_in    (digest_in),
    .mode         (mode),
    .sel          (sel),
    .stream       (bus),
    .busy         (busy),
    .overrun      (overrun)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: stored words, whether anything was captured,
  // whether a stream is running and which word it is on.
  logic [31:0] m_mem [8];
  bit          m_have;
  bit          m_strm;
  bit          m_ovr;
  int          m_pos;
  logic [2:0]  m_sel;

  task automatic model_load();
    for (int i = 0; i < 8; i++)
      m_mem[i] = digest_in[255-32*i -: 32];
  endtask

  task automatic model();
    bit fire, lastf;
    m_sel = sel;
    if (rst) begin
      foreach (m_mem[i]) m_mem[i] = '0;
      m_have = 0; m_strm = 0; m_ovr = 0; m_pos = 0;
      return;
    end
    fire  = m_strm && bus.out_ready;
    lastf = fire && (m_pos == 7);
    if (!m_strm) begin
      if (digest_valid) begin
        model_load();
        m_have = 1; m_strm = mode; m_pos = 0;
      end else if (m_have && mode) begin
        m_strm = 1; m_pos = 0;
      end
    end else begin
      if (digest_valid && !lastf) m_ovr = 1;
      if (lastf) begin
        if (digest_valid) model_load();
        m_strm = mode; m_pos = 0;
      end else if (fire) begin
        m_pos++;
      end
    end
  endtask

  function automatic logic [38:0] expv();
    if (m_strm)
      return {1'b1, m_pos == 7, 1'b1, m_ovr, 3'(m_pos), m_mem[m_pos]};
    else if (m_have)
      return {3'b000, m_ovr, m_sel, m_mem[m_sel]};
    else
      return {3'b000, m_ovr, 3'd0, 32'd0};
  endfunction

  function automatic logic [38:0] obs();
    return {bus.out_valid, bus.out_last, busy, overrun,
            bus.word_idx, bus.word_out};
  endfunction

  function automatic logic [255:0] seq_digest();
    logic [255:0] d;
    for (int i = 0; i < 8; i++)
      d[255-32*i -: 32] = 32'h11111111 * 32'(i + 1);
    return d;
  endfunction

  function automatic logic [255:0] rnd_digest();
    logic [255:0] d;
    for (int i = 0; i < 8; i++) d[32*i +: 32] = $urandom;
    return d;
  endfunction

  task automatic cyc(input bit r, input bit dv, input logic [255:0] d,
                     input bit md, input logic [2:0] s, input bit rdy);
    rst = r; digest_valid = dv; digest_in = d;
    mode = md; sel = s; bus.out_ready = rdy;
    @(posedge clk);
    model();
    #1;
  endtask

  task automatic test_reset();
    cyc(1, 0, '0, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      cyc(0, 0, '0, 1'($urandom), 3'($urandom), 1'($urandom));
      checks++;
      if (obs() !== 39'd0) begin
        errors++;
        $display("FAIL reset_idle k=%0d got %h exp 0", k, obs());
      end
      checks++;
      if (obs() !== expv()) begin
        errors++;
        $display("FAIL reset_model got %h exp %h", obs(), expv());
      end
    end
  endtask

  task automatic test_manual();
    cyc(0, 1, seq_digest(), 0, 0, 0);
    cyc(0, 0, '0, 0, 3, 0);
    checks++;
    if (bus.word_out !== 32'h44444444 || bus.word_idx !== 3'd3
        || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL manual_sel3 got %h/%0d exp 44444444/3",
               bus.word_out, bus.word_idx);
    end
    for (int s = 0; s < 8; s++) begin
      cyc(0, 0, '0, 0, 3'(s), 0);
      checks++;
      if (obs() !== expv()) begin
        errors++;
        $display("FAIL manual s=%0d got %h exp %h", s, obs(), expv());
      end
    end
  endtask

  task automatic test_stream();
    logic [31:0] w;
    cyc(0, 1, seq_digest(), 1, 0, 1);
    for (int k = 0; k < 8; k++) begin
      w = 32'h11111111 * 32'(k + 1);
      checks++;
      if (bus.word_out !== w || bus.out_valid !== 1'b1
          || bus.out_last !== (k == 7) || busy !== 1'b1) begin
        errors++;
        $display("FAIL stream k=%0d got %h last %b exp %h last %b",
                 k, bus.word_out, bus.out_last, w, k == 7);
      end
      checks++;
      if (obs() !== expv()) begin
        errors++;
        $display("FAIL stream_model got %h exp %h", obs(), expv());
      end
      cyc(0, 0, '0, 0, 0, 1);
    end
    checks++;
    if (busy !== 1'b0 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL stream_end busy %b valid %b exp 0 0",
               busy, bus.out_valid);
    end
  endtask

  task automatic test_stall();
    bit done = 0;
    cyc(0, 1, seq_digest(), 1, 0, 0);
    cyc(0, 0, '0, 1, 0, 1);
    cyc(0, 0, '0, 0, 0, 1);
    for (int k = 0; k < 3; k++) begin
      cyc(0, 0, '0, 0, 3'($urandom), 0);
      checks++;
      if (bus.word_out !== 32'h33333333 || bus.out_valid !== 1'b1
          || bus.word_idx !== 3'd2) begin
        errors++;
        $display("FAIL stall k=%0d got %h idx %0d exp 33333333 idx 2",
                 k, bus.word_out, bus.word_idx);
      end
    end
    cyc(0, 0, '0, 0, 0, 1);
    checks++;
    if (bus.word_out !== 32'h44444444 || bus.word_idx !== 3'd3) begin
      errors++;
      $display("FAIL stall_resume got %h idx %0d exp 44444444 idx 3",
               bus.word_out, bus.word_idx);
    end
    for (int k = 0; k < 20 && !done; k++) begin
      cyc(0, 0, '0, 0, 0, 1);
      checks++;
      if (obs() !== expv()) begin
        errors++;
        $display("FAIL stall_model got %h exp %h", obs(), expv());
      end
      done = !busy;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL stall_drain busy 1 exp 0");
    end
  endtask

  task automatic test_overrun();
    logic [255:0] b;
    b = rnd_digest();
    cyc(1, 0, '0, 0, 0, 0);
    cyc(0, 1, seq_digest(), 1, 0, 1);
    for (int k = 0; k < 4; k++) cyc(0, 0, '0, 1, 0, 1);
    cyc(0, 1, b, 1, 0, 1);
    checks++;
    if (overrun !== 1'b1 || bus.word_idx !== 3'd5) begin
      errors++;
      $display("FAIL overrun_set got %b idx %0d exp 1 idx 5",
               overrun, bus.word_idx);
    end
    for (int k = 0; k < 3; k++) cyc(0, 0, '0, 0, 0, 1);
    cyc(0, 0, '0, 0, 0, 0);
    checks++;
    if (bus.word_out !== 32'h11111111 || overrun !== 1'b1) begin
      errors++;
      $display("FAIL overrun_kept got %h ovr %b exp 11111111 ovr 1",
               bus.word_out, overrun);
    end
    checks++;
    if (obs() !== expv()) begin
      errors++;
      $display("FAIL overrun_model got %h exp %h", obs(), expv());
    end
    cyc(1, 0, '0, 0, 0, 0);
    cyc(0, 1, seq_digest(), 1, 0, 1);
    for (int k = 0; k < 7; k++) cyc(0, 0, '0, 1, 0, 1);
    checks++;
    if (bus.out_last !== 1'b1 || bus.word_idx !== 3'd7) begin
      errors++;
      $display("FAIL last_idx got last %b idx %0d exp 1 7",
               bus.out_last, bus.word_idx);
    end
    cyc(0, 1, b, 1, 0, 1);
    checks++;
    if (overrun !== 1'b0 || bus.word_out !== b[255:224]
        || bus.word_idx !== 3'd0 || bus.out_valid !== 1'b1) begin
      errors++;
      $display("FAIL last_capture got %h ovr %b exp %h ovr 0",
               bus.word_out, overrun, b[255:224]);
    end
    checks++;
    if (obs() !== expv()) begin
      errors++;
      $display("FAIL capture_model got %h exp %h", obs(), expv());
    end
  endtask

  task automatic test_reset_mid();
    cyc(1, 0, '0, 0, 0, 0);
    cyc(0, 1, seq_digest(), 1, 0, 1);
    for (int k = 0; k < 5; k++) cyc(0, 0, '0, 1, 0, 1);
    checks++;
    if (bus.word_idx !== 3'd5 || bus.word_out !== 32'h66666666) begin
      errors++;
      $display("FAIL mid_idx5 got %h idx %0d exp 66666666 idx 5",
               bus.word_out, bus.word_idx);
    end
    cyc(1, 0, '0, 1, 0, 1);
    checks++;
    if (bus.out_valid !== 1'b0 || bus.word_out !== 32'd0) begin
      errors++;
      $display("FAIL mid_reset valid %b word %h exp 0 0",
               bus.out_valid, bus.word_out);
    end
    cyc(0, 0, '0, 0, 3, 0);
    checks++;
    if (bus.word_out !== 32'd0 || obs() !== expv()) begin
      errors++;
      $display("FAIL mid_sel_read got %h exp %h", obs(), expv());
    end
  endtask

  task automatic test_random();
    bit md = 0;
    cyc(1, 0, '0, 0, 0, 0);
    for (int k = 0; k < 800; k++) begin
      if ($urandom_range(11, 0) == 0) md = !md;
      cyc($urandom_range(96, 0) == 0, $urandom_range(5, 0) == 0,
          rnd_digest(), md, 3'($urandom), $urandom_range(3, 0) != 0);
      checks++;
      if (obs() !== expv()) begin
        errors++;
        $display("FAIL random k=%0d got %h exp %h", k, obs(), expv());
      end
    end
  endtask

  initial begin
    test_reset();
    test_manual();
    test_stream();
    test_stall();
    test_overrun();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/digest_out_sequencer.md
# digest_out_sequencer

Holds the final 256-bit SHA-256 digest (H0..H7) and presents it one 32-bit word at a time. It supports two modes: manual word selection from the board switches, and a valid/ready word stream toward a downstream consumer (display driver or UART packer). It sits between the hash core's completion output and the output/display logic, and owns the 8:1 word selection for the digest.

## Interface
Parameters:
- WORD_W, 32, digest word width
- NUM_WORDS, 8, words per digest; fixed at 8, index width 3

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- digest_valid  in  1  single-cycle pulse: digest_in is valid this cycle
- digest_in  in  256  packed digest; H0 in [255:224] through H7 in [31:0]
- mode  in  1  0 = manual select, 1 = stream
- sel  in  3  manual word index (switch inputs sw9,sw8,sw7; sw9 = MSB)
- out_ready  in  1  downstream accepts the current word
- word_out  out  32  selected/streamed digest word (registered)
- word_idx  out  3  index of word_out
- out_valid  out  1  stream word valid
- out_last  out  1  high with word 7 while streaming
- busy  out  1  high in STREAM
- overrun  out  1  sticky: a digest was dropped because a stream was in progress

## Operation
- Storage: 8 x 32 register file, loaded in one cycle on an accepted digest_valid.
- States:
  - EMPTY: nothing captured; word_out = 0, out_valid = 0.
  - HOLD: digest stored, no stream in progress.
  - STREAM: words are sent in index order 0..7 under the handshake.
- EMPTY or HOLD with digest_valid: capture the digest. If mode = 1, go to STREAM with idx = 0. Otherwise go to HOLD.
- HOLD, mode = 1, no digest_valid: go to STREAM with idx = 0. This replays the stored digest.
- HOLD, mode = 0: word_out = reg[sel] and word_idx = sel, updated every cycle. out_valid = 0.
- STREAM:
  - out_valid = 1, word_out = reg[idx], out_last = (idx == 7).
  - A handshake is out_valid && out_ready; it advances idx by 1.
  - A handshake at idx 7 goes to HOLD, or to STREAM with idx 0 if mode is still 1. Mode is sampled at the last handshake, so mode = 1 produces continuous replay.
- Mode changes during STREAM are ignored until the last handshake. A stream is never aborted except by rst.
- digest_valid in STREAM, not on the last handshake: the digest is discarded, storage is unchanged, and overrun is set.
- digest_valid on the same cycle as the last handshake: the digest is captured. Next state is STREAM with idx 0 if mode = 1, otherwise HOLD. overrun is not set.
- overrun clears only on rst.
- word_out, word_idx and out_last stay stable while out_valid && !out_ready.

## Timing
- Reset (rst high at an edge): state = EMPTY, storage = 0, idx = 0, word_out = 0, word_idx = 0, out_valid = 0, out_last = 0, busy = 0, overrun = 0.
- rst mid-stream takes effect at the next edge; out_valid is low the following cycle.
- Capture latency: digest_valid at edge N gives storage valid after N.
  - Stream mode: out_valid = 1 with word 0 from cycle N+1.
  - Manual mode: word_out = reg[sel] from cycle N+1.
- Manual select latency: a change of sel at edge N shows on word_out after edge N+1 (one register stage).
- Stream throughput: one word per cycle with out_ready held high. A full digest takes 8 cycles, and word 0 of a replay follows word 7 with no bubble.
- busy equals (state == STREAM) and is registered alongside out_valid.

## Structure
- Package digest_pkg:
  - WORD_W, NUM_WORDS, IDX_W = 3
  - state enum (EMPTY, HOLD, STREAM)
  - digest word array typedef (logic [7:0][31:0])
- Sub-module digest_word_mux: a purely combinational 8:1 x 32-bit selector, indexed by the 3-bit read pointer. The read pointer is sel in HOLD and idx in STREAM. The top block registers its output.
- The top block contains the FSM, index counter, storage, overrun flag and output registers.

## Test plan
- Reset then idle → all outputs 0, state EMPTY.
- Manual mode, digest H0..H7 = 0x11111111 x (i+1), then sel = 3 → word_out = 0x44444444 and word_idx = 3 one cycle after sel.
- Stream mode, out_ready held high → words 0x11111111..0x88888888 on 8 consecutive cycles, out_last only on the 8th, then HOLD.
- Stream with out_ready low for 3 cycles at idx 2 → word_out held at 0x33333333 with out_valid high, then resumes at idx 3.
- Second digest_valid at idx 4 → digest dropped and overrun = 1. The same pulse on the idx-7 handshake → new digest captured and overrun stays 0.
- rst asserted at idx 5 → out_valid = 0, word_out = 0, storage cleared next cycle, and a subsequent sel read returns 0.
